// File: rtl/tail_packer.sv
// rtl/tail_packer.sv - IN-to-OUT word width converter with per-packet framing and tail flush.
module tail_packer #(
  parameter int IN  = 4,
  parameter int OUT = 3,
  parameter int W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_val_i,
  input  logic [W*IN-1:0]            in_data_i,
  input  logic [$clog2(IN+1)-1:0]    in_cnt_i,
  input  logic                       in_last_i,
  output logic                       in_rdy_o,
  output logic                       out_val_o,
  output logic [W*OUT-1:0]           out_data_o,
  output logic [$clog2(OUT+1)-1:0]   out_cnt_o,
  output logic                       out_last_o,
  input  logic                       out_rdy_i
);

  localparam int BUFF = IN + OUT - 1;
  localparam int OCW  = $clog2(OUT + 1);
  localparam int VW   = $clog2(BUFF + 1);
  localparam int BW   = W * BUFF;

  logic [BW-1:0]   mem_q, mem_d;
  logic [VW-1:0]   v_q, v_d;
  logic            pend_q, pend_d;

  logic            push, pop;
  int              in_n, out_n, v_rem;
  logic [W*IN-1:0] in_keep;
  logic [BW-1:0]   in_ext;

  always_comb begin
    in_n  = (int'(in_cnt_i) > IN) ? IN : int'(in_cnt_i);
    out_n = (int'(v_q) > OUT) ? OUT : int'(v_q);

    out_val_o  = (int'(v_q) >= OUT) || pend_q;
    out_cnt_o  = OCW'(out_n);
    out_last_o = pend_q && (int'(v_q) <= OUT);
    out_data_o = '0;
    for (int k = 0; k < OUT; k++) begin
      if (k < out_n) out_data_o[W*k +: W] = mem_q[W*k +: W];
    end

    // Space freed by this cycle's pop counts toward accepting a full input beat.
    pop      = out_val_o && out_rdy_i;
    v_rem    = pop ? int'(v_q) - out_n : int'(v_q);
    in_rdy_o = !pend_q && (v_rem + IN <= BUFF);
    push     = in_val_i && in_rdy_o;

    in_keep = '0;
    for (int k = 0; k < IN; k++) begin
      if (k < in_n) in_keep[W*k +: W] = in_data_i[W*k +: W];
    end
    in_ext = '0;
    in_ext[W*IN-1:0] = in_keep;

    // Entries at or above v are always zero, so appending is a plain OR.
    mem_d  = pop ? (mem_q >> (W * out_n)) : mem_q;
    v_d    = VW'(v_rem);
    pend_d = pend_q;
    if (pop && out_last_o) pend_d = 1'b0;
    if (push) begin
      mem_d = mem_d | (in_ext << (W * v_rem));
      v_d   = VW'(v_rem + in_n);
      if (in_last_i) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q  <= '0;
      v_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      v_q    <= v_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_tail_packer.sv
// tb/tb_tail_packer.sv - directed and randomized checks of tail_packer against a word-queue model.
module tb_tail_packer;
  localparam int IN = 4, OUT = 3, W = 8, BUFF = IN + OUT - 1;

  logic        clk_i = 1'b0;
  logic        rst_i, in_val_i, in_last_i, out_rdy_i;
  logic [31:0] in_data_i;
  logic [2:0]  in_cnt_i;
  logic        in_rdy_o, out_val_o, out_last_o;
  logic [23:0] out_data_o;
  logic [1:0]  out_cnt_o;

  int n_vec = 0, n_bad = 0;

  logic [7:0] mq[$];
  bit         m_pend;

  always #5 clk_i = ~clk_i;

  tail_packer #(.IN(IN), .OUT(OUT), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_val_i(in_val_i), .in_data_i(in_data_i), .in_cnt_i(in_cnt_i), .in_last_i(in_last_i),
    .in_rdy_o(in_rdy_o),
    .out_val_o(out_val_o), .out_data_o(out_data_o), .out_cnt_o(out_cnt_o), .out_last_o(out_last_o),
    .out_rdy_i(out_rdy_i)
  );

  function automatic bit e_val();
    return (mq.size() >= OUT) || m_pend;
  endfunction

  function automatic int e_cnt();
    return (mq.size() > OUT) ? OUT : mq.size();
  endfunction

  function automatic bit e_last();
    return m_pend && (mq.size() <= OUT);
  endfunction

  function automatic bit e_rdy(input bit ordy);
    int occ;
    occ = (e_val() && ordy) ? mq.size() - OUT : mq.size();
    return !m_pend && (occ + IN <= BUFF);
  endfunction

  function automatic logic [23:0] e_data();
    logic [23:0] d = '0;
    for (int k = 0; k < e_cnt(); k++) d[8*k +: 8] = mq[k];
    return d;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] d, input logic [2:0] c,
                        input logic l, input logic r);
    in_val_i = v; in_data_i = d; in_cnt_i = c; in_last_i = l; out_rdy_i = r;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic tick();
    bit do_pop, do_push, o_last, i_last;
    int o_cnt, i_cnt;
    logic [31:0] i_data;
    do_pop  = e_val() && out_rdy_i;
    do_push = in_val_i && e_rdy(out_rdy_i);
    o_cnt   = e_cnt();
    o_last  = e_last();
    i_cnt   = (int'(in_cnt_i) > IN) ? IN : int'(in_cnt_i);
    i_last  = in_last_i;
    i_data  = in_data_i;
    @(posedge clk_i);
    if (do_pop) begin
      repeat (o_cnt) void'(mq.pop_front());
      if (o_last) m_pend = 0;
    end
    if (do_push) begin
      for (int k = 0; k < i_cnt; k++) mq.push_back(i_data[8*k +: 8]);
      if (i_last) m_pend = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0);
    mq.delete();
    m_pend = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0) begin n_bad++; $display("FAIL reset_val got %b want 0", out_val_o); end
    n_vec++; if (out_cnt_o !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", out_cnt_o); end
    n_vec++; if (out_last_o !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", out_last_o); end
    n_vec++; if (out_data_o !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data_o); end
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", in_rdy_o); end
  endtask

  task automatic test_full_beats();
    logic [23:0] got[$];
    int          gcnt[$];
    logic        glast[$];
    logic [23:0] exp_d;
    int          b = 0;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (b < 3) set_in(1, {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 4, 0, 1);
      else       set_in(0, 0, 0, 0, 1);
      @(negedge clk_i);
      if (out_val_o) begin
        got.push_back(out_data_o); gcnt.push_back(int'(out_cnt_o)); glast.push_back(out_last_o);
      end
      if (b < 3 && e_rdy(1'b1)) b++;
      tick();
    end
    n_vec++; if (got.size() != 4) begin n_bad++; $display("FAIL full_beats_count got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      exp_d = {8'(3*k+2), 8'(3*k+1), 8'(3*k)};
      n_vec++; if (got[k] !== exp_d) begin n_bad++; $display("FAIL full_beats_data[%0d] got %h want %h", k, got[k], exp_d); end
      n_vec++; if (gcnt[k] != 3) begin n_bad++; $display("FAIL full_beats_cnt[%0d] got %0d want 3", k, gcnt[k]); end
      n_vec++; if (glast[k] !== 1'b0) begin n_bad++; $display("FAIL full_beats_last[%0d] got %b want 0", k, glast[k]); end
    end
  endtask

  task automatic test_packet_last();
    do_reset();
    set_in(1, 32'h04030201, 4, 0, 1); @(negedge clk_i); tick();
    set_in(1, 32'h00000005, 1, 1, 1); @(negedge clk_i);
    n_vec++; if (out_data_o !== 24'h030201) begin n_bad++; $display("FAIL pkt_b0_data got %h want 030201", out_data_o); end
    n_vec++; if (out_cnt_o !== 2'd3) begin n_bad++; $display("FAIL pkt_b0_cnt got %0d want 3", out_cnt_o); end
    n_vec++; if (out_last_o !== 1'b0) begin n_bad++; $display("FAIL pkt_b0_last got %b want 0", out_last_o); end
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL pkt_b0_rdy got %b want 1", in_rdy_o); end
    tick();
    set_in(1, 32'hDEADBEEF, 4, 0, 0); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL pkt_hold_rdy got %b want 0", in_rdy_o); end
    n_vec++; if (out_val_o !== 1'b1) begin n_bad++; $display("FAIL pkt_b1_val got %b want 1", out_val_o); end
    n_vec++; if (out_data_o !== 24'h000504) begin n_bad++; $display("FAIL pkt_b1_data got %h want 000504", out_data_o); end
    n_vec++; if (out_cnt_o !== 2'd2) begin n_bad++; $display("FAIL pkt_b1_cnt got %0d want 2", out_cnt_o); end
    n_vec++; if (out_last_o !== 1'b1) begin n_bad++; $display("FAIL pkt_b1_last got %b want 1", out_last_o); end
    tick();
    set_in(1, 32'hDEADBEEF, 4, 0, 1); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL pkt_pop_rdy got %b want 0", in_rdy_o); end
    n_vec++; if (out_last_o !== 1'b1) begin n_bad++; $display("FAIL pkt_pop_last got %b want 1", out_last_o); end
    tick();
    set_in(0, 0, 0, 0, 1); @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0) begin n_bad++; $display("FAIL pkt_after_val got %b want 0", out_val_o); end
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL pkt_after_rdy got %b want 1", in_rdy_o); end
  endtask

  task automatic test_zero_last();
    do_reset();
    set_in(1, 32'hFFFFFFFF, 0, 1, 0); @(negedge clk_i); tick();
    set_in(0, 0, 0, 0, 0); @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b1) begin n_bad++; $display("FAIL zero_val got %b want 1", out_val_o); end
    n_vec++; if (out_cnt_o !== 2'd0) begin n_bad++; $display("FAIL zero_cnt got %0d want 0", out_cnt_o); end
    n_vec++; if (out_last_o !== 1'b1) begin n_bad++; $display("FAIL zero_last got %b want 1", out_last_o); end
    n_vec++; if (out_data_o !== 24'h0) begin n_bad++; $display("FAIL zero_data got %h want 0", out_data_o); end
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL zero_rdy got %b want 0", in_rdy_o); end
    tick();
    set_in(0, 0, 0, 0, 1); @(negedge clk_i); tick();
    set_in(1, 32'h12345678, 0, 0, 1); @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0) begin n_bad++; $display("FAIL zero_popped_val got %b want 0", out_val_o); end
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL zero_popped_rdy got %b want 1", in_rdy_o); end
    tick();
    set_in(0, 0, 0, 0, 1); @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0 || out_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL zero_nolast val/cnt got %b/%0d want 0/0", out_val_o, out_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1, 32'h13121110, 4, 0, 0); @(negedge clk_i); tick();
    set_in(0, 0, 0, 0, 0); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_rdy got %b want 0", in_rdy_o); end
    n_vec++; if (out_val_o !== 1'b1) begin n_bad++; $display("FAIL bp_full_val got %b want 1", out_val_o); end
    tick();
    set_in(1, 32'h23222120, 4, 0, 1); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL bp_release_rdy got %b want 1", in_rdy_o); end
    tick();
    set_in(0, 0, 0, 0, 0); @(negedge clk_i);
    n_vec++; if (out_data_o !== 24'h212013) begin n_bad++; $display("FAIL bp_v5_data got %h want 212013", out_data_o); end
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL bp_v5_rdy got %b want 0", in_rdy_o); end
    tick();
    set_in(0, 0, 0, 0, 1); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL bp_v5_pop_rdy got %b want 1", in_rdy_o); end
    tick();
    @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0 || out_cnt_o !== 2'd2) begin
      n_bad++; $display("FAIL bp_v2 val/cnt got %b/%0d want 0/2", out_val_o, out_cnt_o);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    set_in(1, 32'hA3A2A1A0, 7, 0, 0); @(negedge clk_i); tick();
    set_in(0, 0, 0, 0, 0); @(negedge clk_i);
    n_vec++; if (out_data_o !== 24'hA2A1A0) begin n_bad++; $display("FAIL clamp_data got %h want a2a1a0", out_data_o); end
    n_vec++; if (in_rdy_o !== 1'b0) begin n_bad++; $display("FAIL clamp_v4_rdy got %b want 0", in_rdy_o); end
    tick();
    set_in(1, 32'h0, 0, 1, 1); @(negedge clk_i);
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL clamp_pop_rdy got %b want 1", in_rdy_o); end
    tick();
    set_in(0, 0, 0, 0, 1); @(negedge clk_i);
    n_vec++; if (out_data_o !== 24'h0000A3 || out_cnt_o !== 2'd1 || out_last_o !== 1'b1) begin
      n_bad++; $display("FAIL clamp_tail data/cnt/last got %h/%0d/%b want 0000a3/1/1", out_data_o, out_cnt_o, out_last_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1, 32'h0000BBAA, 2, 1, 0); @(negedge clk_i); tick();
    set_in(0, 0, 0, 0, 0); @(negedge clk_i);
    n_vec++; if (out_data_o !== 24'h00BBAA || out_last_o !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre data/last got %h/%b want 00bbaa/1", out_data_o, out_last_o);
    end
    #1 rst_i = 1'b1;
    mq.delete(); m_pend = 0;
    #1;
    n_vec++; if (out_val_o !== 1'b0) begin n_bad++; $display("FAIL mid_async_val got %b want 0", out_val_o); end
    n_vec++; if (out_data_o !== 24'h0) begin n_bad++; $display("FAIL mid_async_data got %h want 0", out_data_o); end
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    n_vec++; if (out_val_o !== 1'b0) begin n_bad++; $display("FAIL mid_post_val got %b want 0", out_val_o); end
    n_vec++; if (in_rdy_o !== 1'b1) begin n_bad++; $display("FAIL mid_post_rdy got %b want 1", in_rdy_o); end
    n_vec++; if (out_data_o !== 24'h0 || out_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL mid_post data/cnt got %h/%0d want 0/0", out_data_o, out_cnt_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
      @(negedge clk_i);
      n_vec++; if (out_val_o !== e_val()) begin n_bad++; $display("FAIL rnd_val cyc %0d got %b want %b", cyc, out_val_o, e_val()); end
      n_vec++; if (int'(out_cnt_o) != e_cnt()) begin n_bad++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, out_cnt_o, e_cnt()); end
      n_vec++; if (out_last_o !== e_last()) begin n_bad++; $display("FAIL rnd_last cyc %0d got %b want %b", cyc, out_last_o, e_last()); end
      n_vec++; if (out_data_o !== e_data()) begin n_bad++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, out_data_o, e_data()); end
      n_vec++; if (in_rdy_o !== e_rdy(out_rdy_i)) begin n_bad++; $display("FAIL rnd_rdy cyc %0d got %b want %b", cyc, in_rdy_o, e_rdy(out_rdy_i)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_beats();
    test_packet_last();
    test_zero_last();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
